dht11_read_scheduler: RTL and testbench

- Controller that sequences a one-shot DHT11 reader front-end. It decides when a read is started, arbitrates between the periodic timer and a manual request, enforces the sensor's minimum inter-read gap, retries failed reads and holds the last good sample.
- Sits between the DHT11 bit-level reader and the display/UART consumers, at the 50 MHz system clock.

---
 rtl/dht11_pkg.sv | 32 +++
 rtl/dht11_read_scheduler_if.sv | 22 ++
 rtl/sat_counter.sv | 26 ++
 rtl/dht11_read_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dht11_read_scheduler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 read path.
// Scheduler states, default 50 MHz timing and reader protocol timing.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    RETRY = 3'd4
  } state_t;

  typedef logic [7:0] rd_byte_t;

  localparam int unsigned PERIOD_CYC_DEF  = 150_000_000;
  localparam int unsigned MIN_GAP_CYC_DEF = 100_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 2_500_000;
  localparam int unsigned MAX_RETRY_DEF   = 3;
  localparam int unsigned STALE_CYC_DEF   = 500_000_000;

  // Reader front-end timing: 18 ms host start, 40 us release,
  // a high pulse beyond 50 us decodes as '1', 40-bit frame.
  localparam int unsigned START_LOW_CYC = 900_000;
  localparam int unsigned START_REL_CYC = 2_000;
  localparam int unsigned BIT_ONE_CYC   = 2_500;
  localparam int unsigned FRAME_BITS    = 40;

  function automatic int unsigned cnt_w(input int unsigned lim);
    return (lim < 2) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/dht11_read_scheduler_if.sv
// dht11_read_scheduler_if: launch/complete handshake to the reader.
// master = scheduler, slave = DHT11 bit-level reader.
interface dht11_read_scheduler_if;
  import dht11_pkg::*;

  logic     rd_start;
  logic     rd_busy;
  logic     rd_done;
  logic     rd_ok;
  rd_byte_t rd_hum;
  rd_byte_t rd_temp;

  modport master (
    output rd_start,
    input  rd_busy, rd_done, rd_ok, rd_hum, rd_temp
  );

  modport slave (
    input  rd_start,
    output rd_busy, rd_done, rd_ok, rd_hum, rd_temp
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter with clear, enable and saturation at LIMIT.
// Reset value is a parameter so a counter can start already full.
module sat_counter #(
  parameter int unsigned W       = 8,
  parameter int unsigned LIMIT   = 255,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] LIM  = W'(LIMIT);
  localparam logic [W-1:0] INIT = W'(RST_VAL);

  // Clear wins over count; hold once LIMIT is reached
  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= INIT;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != LIM)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dht11_read_scheduler.sv
// dht11_read_scheduler: decides when the DHT11 reader runs, retries
// failures, enforces the sensor rest gap and holds the last good sample.
module dht11_read_scheduler
  import dht11_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int unsigned MIN_GAP_CYC = MIN_GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF,
  parameter int unsigned STALE_CYC   = STALE_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_manual,
  dht11_read_scheduler_if.master  rd,
  output logic [7:0]              hum,
  output logic [7:0]              temp,
  output logic                    sample_valid,
  output logic                    new_sample,
  output logic                    stale,
  output logic [7:0]              err_count,
  output logic [2:0]              state_dbg
);
  localparam int unsigned PW = cnt_w(PERIOD_CYC - 1);
  localparam int unsigned GW = cnt_w(MIN_GAP_CYC);
  localparam int unsigned TW = cnt_w(TIMEOUT_CYC - 1);
  localparam int unsigned SW = cnt_w(STALE_CYC);
  localparam int unsigned RW = cnt_w(MAX_RETRY);

  state_t        state;
  logic          pending;
  logic          ok_q;
  logic          start_q;
  logic [RW-1:0] retry;
  logic [PW-1:0] per_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stale_cnt;

  logic tick;
  logic gap_ok;
  logic done_w;
  logic tmo;
  logic good;
  logic bad;

  assign tick   = per_cnt == PW'(PERIOD_CYC - 1);
  assign gap_ok = gap_cnt == GW'(MIN_GAP_CYC);
  assign done_w = (state == WAIT) && rd.rd_done;
  assign tmo    = (state == WAIT) &&
                  (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign good   = (state == EVAL) && ok_q;
  assign bad    = (state == EVAL) && !ok_q;

  assign rd.rd_start = start_q;
  assign stale       = stale_cnt == SW'(STALE_CYC);
  assign state_dbg   = state;

  // Free-running read period; the wrap cycle requests a read
  always_ff @(posedge clk) begin
    if (!rst)
      per_cnt <= '0;
    else if (tick)
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + 1'b1;
  end

  sat_counter #(
    .W(GW), .LIMIT(MIN_GAP_CYC), .RST_VAL(MIN_GAP_CYC)
  ) u_gap (
    .clk(clk), .rst(rst),
    .clr(done_w || tmo), .en(1'b1),
    .cnt(gap_cnt)
  );

  sat_counter #(
    .W(TW), .LIMIT(TIMEOUT_CYC - 1), .RST_VAL(0)
  ) u_tmo (
    .clk(clk), .rst(rst),
    .clr(state == ISSUE), .en(state == WAIT),
    .cnt(tmo_cnt)
  );

  sat_counter #(
    .W(SW), .LIMIT(STALE_CYC), .RST_VAL(0)
  ) u_stale (
    .clk(clk), .rst(rst),
    .clr(good), .en(1'b1),
    .cnt(stale_cnt)
  );

  sat_counter #(
    .W(8), .LIMIT(255), .RST_VAL(0)
  ) u_err (
    .clk(clk), .rst(rst),
    .clr(1'b0), .en(bad),
    .cnt(err_count)
  );

  // Read sequencing FSM with registered launch and sample outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pending      <= 1'b0;
      ok_q         <= 1'b0;
      start_q      <= 1'b0;
      retry        <= '0;
      hum          <= '0;
      temp         <= '0;
      sample_valid <= 1'b0;
      new_sample   <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      new_sample <= 1'b0;
      if (tick || req_manual)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pending && gap_ok && !rd.rd_busy) begin
            pending <= 1'b0;
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (rd.rd_done) begin
            ok_q  <= rd.rd_ok;
            state <= EVAL;
            if (rd.rd_ok) begin
              hum          <= rd.rd_hum;
              temp         <= rd.rd_temp;
              sample_valid <= 1'b1;
              new_sample   <= 1'b1;
            end
          end else if (tmo) begin
            ok_q  <= 1'b0;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (ok_q) begin
            retry <= '0;
            state <= IDLE;
          end else if (retry < RW'(MAX_RETRY)) begin
            retry <= retry + 1'b1;
            state <= RETRY;
          end else begin
            retry <= '0;
            state <= IDLE;
          end
        end
        RETRY: begin
          if (gap_ok && !rd.rd_busy) begin
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dht11_read_scheduler.sv
// tb_dht11_read_scheduler: scoreboard bench for the read scheduler.
// Good reads push {hum,temp}; each new_sample pops and compares.
module tb_dht11_read_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_manual = 1'b0;
  logic [7:0] hum;
  logic [7:0] temp;
  logic       sample_valid;
  logic       new_sample;
  logic       stale;
  logic [7:0] err_count;
  logic [2:0] state_dbg;

  dht11_read_scheduler_if rd();

  dht11_read_scheduler #(
    .PERIOD_CYC(1000), .MIN_GAP_CYC(200), .TIMEOUT_CYC(50),
    .MAX_RETRY(2), .STALE_CYC(3000)
  ) dut (
    .clk(clk), .rst(rst), .req_manual(req_manual), .rd(rd),
    .hum(hum), .temp(temp), .sample_valid(sample_valid),
    .new_sample(new_sample), .stale(stale),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  int n_ns = 0;
  logic ns_prev = 1'b0;
  logic [15:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (rd.rd_start === 1'b1) n_starts++;
    if (new_sample === 1'b1) begin
      n_ns++;
      chk("ns_width", {31'd0, ns_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("ns_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_hum", {24'd0, hum}, {24'd0, e[15:8]});
        chk("sb_temp", {24'd0, temp}, {24'd0, e[7:0]});
      end
    end
    ns_prev = new_sample;
  end

  task automatic do_reset(output int rel);
    @(negedge clk);
    rst = 1'b0;
    req_manual = 1'b0;
    rd.rd_busy = 1'b0;
    rd.rd_done = 1'b0;
    rd.rd_ok = 1'b0;
    rd.rd_hum = 8'h00;
    rd.rd_temp = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rel = cyc;
  endtask

  task automatic wait_start(input string tag, input int limit,
                            output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd.rd_start !== 1'b1 && n < limit);
    chk({tag, "_seen"}, {31'd0, rd.rd_start}, 32'd1);
    at = cyc;
  endtask

  task automatic respond_ok(input logic [7:0] h, input logic [7:0] t,
                            input int lat, output int c_done);
    rd.rd_busy = 1'b1;
    repeat (lat) @(negedge clk);
    rd.rd_done = 1'b1;
    rd.rd_ok = 1'b1;
    rd.rd_hum = h;
    rd.rd_temp = t;
    sb_q.push_back({h, t});
    c_done = cyc;
    @(negedge clk);
    rd.rd_done = 1'b0;
    rd.rd_ok = 1'b0;
    rd.rd_busy = 1'b0;
  endtask

  task automatic pulse_req();
    req_manual = 1'b1;
    @(negedge clk);
    req_manual = 1'b0;
  endtask

  initial begin
    int rel, s1, s2, s3, cd, n0, k;
    rd.rd_busy = 1'b0;
    rd.rd_done = 1'b0;
    rd.rd_ok = 1'b0;
    rd.rd_hum = 8'h00;
    rd.rd_temp = 8'h00;

    // reset state
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_hum", {24'd0, hum}, 32'd0);
    chk("rst_temp", {24'd0, temp}, 32'd0);
    chk("rst_flags", {28'd0, sample_valid, new_sample, stale,
        rd.rd_start}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);

    // first periodic read and a good answer
    do_reset(rel);
    wait_start("first", 1100, s1);
    chk("first_start_cyc", s1 - rel, 1001);
    respond_ok(8'h37, 8'h19, 5, cd);
    chk("good_hum", {24'd0, hum}, 32'h37);
    chk("good_temp", {24'd0, temp}, 32'h19);
    chk("good_ns", {31'd0, new_sample}, 32'd1);
    chk("good_valid", {31'd0, sample_valid}, 32'd1);
    chk("good_err", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    chk("ns_low", {31'd0, new_sample}, 32'd0);

    // manual requests held off by the rest gap, merged into one read
    while (cyc < cd + 10) @(negedge clk);
    n0 = n_starts;
    pulse_req();
    while (cyc < cd + 30) @(negedge clk);
    pulse_req();
    while (cyc < cd + 60) @(negedge clk);
    pulse_req();
    wait_start("man", 300, s2);
    chk("man_start_cyc", s2 - cd, 202);
    respond_ok(8'h40, 8'h1a, 5, cd);
    n0 = n_starts - n0;
    chk("man_starts", n0, 1);
    n0 = n_starts;
    repeat (300) @(negedge clk);
    chk("man_one_read", n_starts - n0, 0);

    // reader never answers: retries, then round abandoned
    do_reset(rel);
    wait_start("nr1", 1100, s1);
    chk("nr1_cyc", s1 - rel, 1001);
    wait_start("nr2", 400, s2);
    chk("nr_gap12", s2 - s1, 252);
    wait_start("nr3", 400, s3);
    chk("nr_gap23", s3 - s2, 252);
    repeat (60) @(negedge clk);
    chk("nr_err", {24'd0, err_count}, 32'd3);
    chk("nr_state", {29'd0, state_dbg}, 32'd0);
    chk("nr_hum", {24'd0, hum}, 32'd0);
    chk("nr_valid", {31'd0, sample_valid}, 32'd0);
    while (cyc < rel + 2999) @(negedge clk);
    chk("stale_before", {31'd0, stale}, 32'd0);
    @(negedge clk);
    chk("stale_after", {31'd0, stale}, 32'd1);

    // reset during WAIT, then a late completion
    do_reset(rel);
    wait_start("rw", 1100, s1);
    rd.rd_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rw_in_wait", {29'd0, state_dbg}, 32'd2);
    n0 = n_ns;
    do_reset(rel);
    repeat (5) @(negedge clk);
    rd.rd_done = 1'b1;
    rd.rd_ok = 1'b1;
    rd.rd_hum = 8'haa;
    rd.rd_temp = 8'hbb;
    @(negedge clk);
    rd.rd_done = 1'b0;
    rd.rd_ok = 1'b0;
    for (k = 0; k < 5; k++) @(negedge clk);
    chk("rw_hum", {24'd0, hum}, 32'd0);
    chk("rw_temp", {24'd0, temp}, 32'd0);
    chk("rw_flags", {29'd0, sample_valid, stale, rd.rd_start},
        32'd0);
    chk("rw_err", {24'd0, err_count}, 32'd0);
    chk("rw_state", {29'd0, state_dbg}, 32'd0);
    chk("rw_no_ns", n_ns - n0, 0);

    // completion lands on the timeout cycle
    wait_start("tc", 1100, s1);
    chk("tc_cyc", s1 - rel, 1001);
    respond_ok(8'h2a, 8'h11, 50, cd);
    chk("tc_hum", {24'd0, hum}, 32'h2a);
    chk("tc_err", {24'd0, err_count}, 32'd0);
    chk("tc_state", {29'd0, state_dbg}, 32'd3);
    repeat (3) @(negedge clk);
    chk("tc_idle", {29'd0, state_dbg}, 32'd0);
    chk("tc_err_late", {24'd0, err_count}, 32'd0);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
